// File: rtl/hline_burst_arb.sv
// hline_burst_arb: round-robin arbiter in front of a single AXI burst master.
// Optional watchdog on the WAIT state: define ARB_WATCHDOG_EN.
module hline_burst_arb #(
    parameter int NREQ    = 3,
    parameter int AW      = 32,
    parameter int LW      = 9,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_rnw,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*LW-1:0] req_len,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done_out,
    output logic              m_go,
    output logic              m_rnw,
    output logic [AW-1:0]     m_addr,
    output logic [LW-1:0]     m_len,
    input  logic              axi_done,
    output logic              timeout_flag,
    output logic [1:0]        curr_state
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_own;
    logic [IW-1:0]   w_win;
    logic            w_any;
    logic [LW-1:0]   w_len_raw;
    logic [LW-1:0]   w_len_sat;
    logic            w_wd_expire;

    // Winner is the first requester after the previous owner, wrapping around
    always_comb begin
        w_any = 1'b0;
        w_win = r_last;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_any && req[IW'((int'(r_last) + k) % NREQ)]) begin
                w_any = 1'b1;
                w_win = IW'((int'(r_last) + k) % NREQ);
            end
        end
    end

    // Bursts longer than 256 words are clipped to the AXI maximum
    always_comb begin
        w_len_raw = req_len[int'(w_win)*LW +: LW];
        w_len_sat = (w_len_raw > LW'(256)) ? LW'(256) : w_len_raw;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; zero-length bursts skip the master entirely
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_any) w_next = (w_len_raw == '0) ? S_RELEASE : S_ISSUE;
            S_ISSUE:   w_next = S_WAIT;
            S_WAIT:    if (axi_done || w_wd_expire) w_next = S_RELEASE;
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Latch the winner's burst on grant; rotate priority on release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt    <= '0;
            m_rnw  <= 1'b0;
            m_addr <= '0;
            m_len  <= '0;
            r_own  <= '0;
            r_last <= IW'(NREQ - 1);
        end else if (r_state == S_IDLE && w_any) begin
            gnt    <= NREQ'(1) << w_win;
            m_rnw  <= req_rnw[w_win];
            m_addr <= req_addr[int'(w_win)*AW +: AW];
            m_len  <= w_len_sat;
            r_own  <= w_win;
        end else if (r_state == S_RELEASE) begin
            gnt    <= '0;
            r_last <= r_own;
        end
    end

    assign m_go       = (r_state == S_ISSUE);
    assign done_out   = (r_state == S_RELEASE) ? gnt : '0;
    assign curr_state = r_state;

`ifdef ARB_WATCHDOG_EN
    logic [15:0] r_wd_cnt;
    logic        r_to;

    // Count WAIT cycles; the flag sticks once the master misses the deadline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= '0;
            r_to     <= 1'b0;
        end else begin
            if (r_state == S_ISSUE)     r_wd_cnt <= '0;
            else if (r_state == S_WAIT) r_wd_cnt <= r_wd_cnt + 16'd1;
            if (w_wd_expire && !axi_done) r_to <= 1'b1;
        end
    end

    assign w_wd_expire  = (r_state == S_WAIT) && (r_wd_cnt == 16'(TIMEOUT - 1));
    assign timeout_flag = r_to;
`else
    logic w_unused_to;
    assign w_unused_to  = (TIMEOUT > 0);
    assign w_wd_expire  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_hline_burst_arb.sv
// Scoreboard bench for hline_burst_arb: expected go/done events are queued
// by the stimulus and consumed by an independent monitor.
module tb_hline_burst_arb;

`ifdef ARB_WATCHDOG_EN
    localparam int TO = 16;
`else
    localparam int TO = 4096;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  req_rnw = '0;
    logic [95:0] req_addr = '0;
    logic [26:0] req_len = '0;
    logic        axi_done = 1'b0;
    logic [2:0]  gnt;
    logic [2:0]  done_out;
    logic        m_go;
    logic        m_rnw;
    logic [31:0] m_addr;
    logic [8:0]  m_len;
    logic        timeout_flag;
    logic [1:0]  curr_state;

    hline_burst_arb #(.NREQ(3), .AW(32), .LW(9), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rnw(req_rnw),
        .req_addr(req_addr), .req_len(req_len), .gnt(gnt),
        .done_out(done_out), .m_go(m_go), .m_rnw(m_rnw), .m_addr(m_addr),
        .m_len(m_len), .axi_done(axi_done), .timeout_flag(timeout_flag),
        .curr_state(curr_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_go;
        logic [2:0]  vec;
        logic [31:0] addr;
        logic [8:0]  len;
        logic        rnw;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   inv_bad = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_go(input logic [2:0] v, input logic [31:0] a,
                           input logic [8:0] l, input logic r);
        exp_t e;
        e.is_go = 1'b1; e.vec = v; e.addr = a; e.len = l; e.rnw = r;
        q.push_back(e);
    endtask

    task automatic push_done(input logic [2:0] v);
        exp_t e;
        e.is_go = 1'b0; e.vec = v; e.addr = '0; e.len = '0; e.rnw = 1'b0;
        q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic r, input logic [31:0] a,
                           input logic [8:0] l);
        req_rnw[i] = r;
        req_addr[i*32 +: 32] = a;
        req_len[i*9 +: 9] = l;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (curr_state == s) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found && curr_state == s) found = 1'b1;
        chk("wait_state", {63'd0, found}, 64'd1);
    endtask

    // Wait for WAIT, hold n cycles, complete the burst, check the done pulse
    task automatic serve(input int idx, input int n);
        logic [2:0] oh;
        oh = 3'(1 << idx);
        wait_state(2'd2, 20);
        chk("wait_gnt", {61'd0, gnt}, {61'd0, oh});
        repeat (n) tick();
        axi_done = 1'b1;
        tick();
        axi_done = 1'b0;
        chk("rel_state", {62'd0, curr_state}, 64'd3);
        chk("rel_done", {61'd0, done_out}, {61'd0, oh});
    endtask

    // Monitor: every go/done event must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (!$onehot0(gnt)) inv_bad = 1'b1;
            if (curr_state == 2'd0 && (gnt != 0 || done_out != 0)) inv_bad = 1'b1;
            if (m_go) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL go_unexpected: got gnt %0h expected no event", gnt);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("go_kind", 64'd1, {63'd0, e.is_go});
                    chk("go_gnt", {61'd0, gnt}, {61'd0, e.vec});
                    chk("go_addr", {32'd0, m_addr}, {32'd0, e.addr});
                    chk("go_len", {55'd0, m_len}, {55'd0, e.len});
                    chk("go_rnw", {63'd0, m_rnw}, {63'd0, e.rnw});
                end
            end
            if (done_out != 0) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL done_unexpected: got %0h expected no event", done_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_kind", 64'd0, {63'd0, e.is_go});
                    chk("done_vec", {61'd0, done_out}, {61'd0, e.vec});
                end
            end
        end
    end

    initial begin
        int n;
        #1;
        chk("rst_gnt", {61'd0, gnt}, 64'd0);
        chk("rst_done", {61'd0, done_out}, 64'd0);
        chk("rst_go", {63'd0, m_go}, 64'd0);
        chk("rst_rnw", {63'd0, m_rnw}, 64'd0);
        chk("rst_addr", {32'd0, m_addr}, 64'd0);
        chk("rst_len", {55'd0, m_len}, 64'd0);
        chk("rst_to", {63'd0, timeout_flag}, 64'd0);
        chk("rst_state", {62'd0, curr_state}, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single read burst from requester 0
        set_req(0, 1'b1, 32'h1000_0000, 9'd256);
        push_go(3'b001, 32'h1000_0000, 9'd256, 1'b1);
        push_done(3'b001);
        req = 3'b001;
        tick();
        chk("t1_gnt", {61'd0, gnt}, 64'b001);
        chk("t1_go", {63'd0, m_go}, 64'd1);
        chk("t1_state", {62'd0, curr_state}, 64'd1);
        tick();
        chk("t1_go_off", {63'd0, m_go}, 64'd0);
        chk("t1_wait", {62'd0, curr_state}, 64'd2);
        repeat (10) tick();
        axi_done = 1'b1;
        tick();
        axi_done = 1'b0;
        chk("t1_done", {61'd0, done_out}, 64'b001);
        chk("t1_gnt_rel", {61'd0, gnt}, 64'b001);
        req = 3'b000;
        tick();
        chk("t1_gnt_off", {61'd0, gnt}, 64'd0);
        chk("t1_done_off", {61'd0, done_out}, 64'd0);

        // All three requesting: strict rotation 0,1,2,0,1,2 after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++)
            set_req(k, k[0], 32'h2000_0000 + 32'(k * 'h100), 9'(16 + k));
        for (int r = 0; r < 6; r++) begin
            push_go(3'(1 << (r % 3)), 32'h2000_0000 + 32'((r % 3) * 'h100),
                    9'(16 + r % 3), 1'((r % 3) & 1));
            push_done(3'(1 << (r % 3)));
        end
        req = 3'b111;
        for (int r = 0; r < 6; r++) begin
            serve(r % 3, 1 + r);
            if (r == 5) req = 3'b000;
            tick();
        end

        // Zero-length burst: no go, done in the grant cycle
        set_req(1, 1'b0, 32'h3000_0000, 9'd0);
        push_done(3'b010);
        req = 3'b010;
        tick();
        chk("z_state", {62'd0, curr_state}, 64'd3);
        chk("z_gnt", {61'd0, gnt}, 64'b010);
        chk("z_done", {61'd0, done_out}, 64'b010);
        chk("z_go", {63'd0, m_go}, 64'd0);
        chk("z_len", {55'd0, m_len}, 64'd0);
        req = 3'b000;
        tick();
        chk("z_idle", {62'd0, curr_state}, 64'd0);

        // Oversized burst saturates to 256
        set_req(2, 1'b1, 32'h4000_0000, 9'd300);
        push_go(3'b100, 32'h4000_0000, 9'd256, 1'b1);
        push_done(3'b100);
        req = 3'b100;
        serve(2, 2);
        chk("sat_len", {55'd0, m_len}, 64'd256);
        req = 3'b000;
        tick();

        // Spurious axi_done in IDLE, then req dropped during WAIT
        axi_done = 1'b1;
        tick();
        axi_done = 1'b0;
        chk("sp_state", {62'd0, curr_state}, 64'd0);
        chk("sp_gnt", {61'd0, gnt}, 64'd0);
        tick();
        chk("sp_state2", {62'd0, curr_state}, 64'd0);
        set_req(2, 1'b0, 32'h5000_0000, 9'd8);
        push_go(3'b100, 32'h5000_0000, 9'd8, 1'b0);
        push_done(3'b100);
        req = 3'b100;
        wait_state(2'd2, 20);
        req = 3'b000;
        serve(2, 3);
        tick();

`ifdef ARB_WATCHDOG_EN
        // Watchdog expiry: done 16 cycles into WAIT, sticky flag
        set_req(0, 1'b0, 32'h8000_0000, 9'd32);
        push_go(3'b001, 32'h8000_0000, 9'd32, 1'b0);
        push_done(3'b001);
        req = 3'b001;
        wait_state(2'd2, 20);
        req = 3'b000;
        n = 0;
        while (done_out == 0 && n < 40) begin
            tick();
            n++;
        end
        chk("wd_cycles", 64'(n), 64'd16);
        chk("wd_flag", {63'd0, timeout_flag}, 64'd1);
        tick();
        axi_done = 1'b1;
        tick();
        axi_done = 1'b0;
        chk("wd_late", {62'd0, curr_state}, 64'd0);
        chk("wd_sticky", {63'd0, timeout_flag}, 64'd1);
        set_req(0, 1'b1, 32'h9000_0000, 9'd4);
        push_go(3'b001, 32'h9000_0000, 9'd4, 1'b1);
        req = 3'b001;
        wait_state(2'd2, 20);
        req = 3'b000;
        repeat (3) tick();
`else
        // No watchdog: WAIT holds indefinitely
        n = 0;
        set_req(0, 1'b1, 32'h9000_0000, 9'd4);
        push_go(3'b001, 32'h9000_0000, 9'd4, 1'b1);
        req = 3'b001;
        wait_state(2'd2, 20);
        req = 3'b000;
        repeat (5000) tick();
        chk("nowd_state", {62'd0, curr_state}, 64'd2);
        chk("nowd_gnt", {61'd0, gnt}, 64'b001);
        chk("nowd_flag", {63'd0, timeout_flag}, 64'd0);
`endif

        // Asynchronous reset in WAIT: outputs clear between edges
        #3;
        reset = 1'b1;
        #2;
        chk("ar_gnt", {61'd0, gnt}, 64'd0);
        chk("ar_done", {61'd0, done_out}, 64'd0);
        chk("ar_go", {63'd0, m_go}, 64'd0);
        chk("ar_addr", {32'd0, m_addr}, 64'd0);
        chk("ar_len", {55'd0, m_len}, 64'd0);
        chk("ar_rnw", {63'd0, m_rnw}, 64'd0);
        chk("ar_to", {63'd0, timeout_flag}, 64'd0);
        chk("ar_state", {62'd0, curr_state}, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        set_req(1, 1'b1, 32'h6000_0000, 9'd4);
        set_req(2, 1'b0, 32'h7000_0000, 9'd4);
        push_go(3'b010, 32'h6000_0000, 9'd4, 1'b1);
        push_done(3'b010);
        req = 3'b110;
        serve(1, 1);
        req = 3'b000;
        tick();
        tick();

        chk("sb_empty", 64'(q.size()), 64'd0);
        chk("gnt_invariant", {63'd0, inv_bad}, 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
